// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks in-flight loads per destination register and raises decode stalls.
// Optional macro LSB_RESP_BYPASS_EN lets a same-cycle response mask RAW/WAW/capacity hazards.
module load_scoreboard #(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned RW             = $clog2(NUM_REGS),
    localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [RW-1:0] issue_rd,
    input  logic          resp_valid,
    input  logic [RW-1:0] resp_rd,
    input  logic [RW-1:0] rs1_d,
    input  logic [RW-1:0] rs2_d,
    input  logic [RW-1:0] rd_d,
    input  logic          rd_we_d,
    input  logic          is_load_d,
    output logic          issue_ready,
    output logic          stall,
    output logic          flush,
    output logic          flag,
    output logic [CW-1:0] outstanding,
    output logic          err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:1] r_pending;
    logic [CW-1:0]       r_count;
    logic                r_err;

    logic [NUM_REGS-1:0] w_pend;
    logic [NUM_REGS-1:1] w_pending_nxt;
    logic [CW-1:0]       w_count_nxt;
    logic                w_err_nxt;
    logic                w_full;
    logic                w_empty;
    logic                w_issue_ok;
    logic                w_resp_ok;
    logic                w_err_over;
    logic                w_err_under;
    logic                w_err_dup;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_cap;
    logic                w_hazard;

    // Bit 0 is a constant zero so x0 lookups never report a hazard.
    assign w_pend  = {r_pending, 1'b0};
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Overflowing issues and underflowing responses are dropped, not counted.
    assign w_issue_ok = issue_valid && !(w_full && !resp_valid);
    assign w_resp_ok  = resp_valid && !w_empty;

    assign w_err_over  = issue_valid && w_full && !resp_valid;
    assign w_err_under = resp_valid && w_empty;
    assign w_err_dup   = issue_valid && (issue_rd != '0) && w_pend[issue_rd]
                         && !(resp_valid && (resp_rd == issue_rd));

    always_comb begin
        w_pending_nxt = r_pending;
        if (resp_valid && (resp_rd != '0)) begin
            w_pending_nxt[resp_rd] = 1'b0;
        end
        // Set after clear so a same-cycle issue/response to one rd stays pending.
        if (w_issue_ok && (issue_rd != '0)) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_issue_ok, w_resp_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    assign w_err_nxt = r_err || w_err_over || w_err_under || w_err_dup;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_err     <= w_err_nxt;
        end
    end

`ifdef LSB_RESP_BYPASS_EN
    assign w_raw1 = (rs1_d != '0) && w_pend[rs1_d] && !(resp_valid && (resp_rd == rs1_d));
    assign w_raw2 = (rs2_d != '0) && w_pend[rs2_d] && !(resp_valid && (resp_rd == rs2_d));
    assign w_waw  = rd_we_d && (rd_d != '0) && w_pend[rd_d]
                    && !(resp_valid && (resp_rd == rd_d));
    assign w_cap  = is_load_d && w_full && !resp_valid;
`else
    assign w_raw1 = (rs1_d != '0) && w_pend[rs1_d];
    assign w_raw2 = (rs2_d != '0) && w_pend[rs2_d];
    assign w_waw  = rd_we_d && (rd_d != '0) && w_pend[rd_d];
    assign w_cap  = is_load_d && w_full;
`endif

    assign w_hazard    = w_raw1 || w_raw2 || w_waw || w_cap;
    assign stall       = w_hazard;
    assign flush       = w_hazard;
    assign flag        = w_hazard;
    assign issue_ready = !w_full;
    assign outstanding = r_count;
    assign err         = r_err;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed self-checking bench for load_scoreboard; expectations follow LSB_RESP_BYPASS_EN.
module tb_load_scoreboard;

`ifdef LSB_RESP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       resp_valid;
    logic [4:0] resp_rd;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       rd_we_d;
    logic       is_load_d;
    logic       issue_ready;
    logic       stall;
    logic       flush;
    logic       flag;
    logic [2:0] outstanding;
    logic       err;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    load_scoreboard #(
        .NUM_REGS       (32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .resp_valid (resp_valid),
        .resp_rd    (resp_rd),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_d       (rd_d),
        .rd_we_d    (rd_we_d),
        .is_load_d  (is_load_d),
        .issue_ready(issue_ready),
        .stall      (stall),
        .flush      (flush),
        .flag       (flag),
        .outstanding(outstanding),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hz(input string tag, input logic exp);
        #1;
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp});
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, exp});
        check({tag, ".flag"},  {31'd0, flag},  {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 1'b1; issue_rd = 5'd5;
        resp_valid = 1'b0; resp_rd = '0; rs1_d = 5'd5; rs2_d = '0;
        rd_d = '0; rd_we_d = 1'b0; is_load_d = 1'b0;

        // Reset held with an issue asserted
        tick(); tick();
        rst_n = 1'b1; issue_valid = 1'b0;
        chk_hz("rst", 1'b0);
        check("rst.outstanding", {29'd0, outstanding}, 32'd0);
        check("rst.err", {31'd0, err}, 32'd0);
        check("rst.issue_ready", {31'd0, issue_ready}, 32'd1);

        // RAW: issue rd=5, response three cycles later
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_d = '0;
        chk_hz("raw.c0", 1'b0);
        tick();
        issue_valid = 1'b0; rs1_d = 5'd5;
        chk_hz("raw.c1", 1'b1);
        check("raw.out1", {29'd0, outstanding}, 32'd1);
        tick();
        chk_hz("raw.c2", 1'b1);
        tick();
        resp_valid = 1'b1; resp_rd = 5'd5;
        chk_hz("raw.c3", !BYP);
        tick();
        resp_valid = 1'b0;
        chk_hz("raw.c4", 1'b0);
        check("raw.out4", {29'd0, outstanding}, 32'd0);
        rs1_d = '0;

        // WAW on rd=7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; rd_d = 5'd7; rd_we_d = 1'b1;
        chk_hz("waw.hit", 1'b1);
        rd_we_d = 1'b0;
        chk_hz("waw.nowe", 1'b0);
        rd_we_d = 1'b1; resp_valid = 1'b1; resp_rd = 5'd7;
        chk_hz("waw.resp", !BYP);
        tick();
        resp_valid = 1'b0;
        chk_hz("waw.clr", 1'b0);
        rd_we_d = 1'b0; rd_d = '0;

        // x0 destination: counted but never tracked
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0; rs1_d = '0; rs2_d = '0;
        chk_hz("x0", 1'b0);
        check("x0.out", {29'd0, outstanding}, 32'd1);
        resp_valid = 1'b1; resp_rd = 5'd0;
        tick();
        resp_valid = 1'b0;
        check("x0.drain", {29'd0, outstanding}, 32'd0);
        check("x0.err", {31'd0, err}, 32'd0);

        // Capacity: fill with rd 1..4
        for (int i = 1; i <= 4; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i);
            tick();
        end
        issue_valid = 1'b0;
        check("cap.out", {29'd0, outstanding}, 32'd4);
        check("cap.ready", {31'd0, issue_ready}, 32'd0);
        check("cap.err0", {31'd0, err}, 32'd0);
        is_load_d = 1'b1;
        chk_hz("cap.load", 1'b1);
        resp_valid = 1'b1; resp_rd = 5'd0;
        chk_hz("cap.load_resp", !BYP);
        resp_valid = 1'b0; is_load_d = 1'b0;
        rs2_d = 5'd3;
        chk_hz("cap.rs2", 1'b1);
        rs2_d = '0;
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0;
        check("cap.over_err", {31'd0, err}, 32'd1);
        check("cap.over_out", {29'd0, outstanding}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            resp_valid = 1'b1; resp_rd = 5'(i);
            tick();
        end
        resp_valid = 1'b0;
        check("cap.drain", {29'd0, outstanding}, 32'd0);
        check("cap.sticky", {31'd0, err}, 32'd1);
        check("cap.ready1", {31'd0, issue_ready}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("cap.rst_err", {31'd0, err}, 32'd0);

        // Same-cycle issue and response to rd=9
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        resp_valid = 1'b1; resp_rd = 5'd9;
        tick();
        issue_valid = 1'b0; resp_valid = 1'b0; rs1_d = 5'd9;
        check("sim.out", {29'd0, outstanding}, 32'd1);
        check("sim.err", {31'd0, err}, 32'd0);
        chk_hz("sim.pend", 1'b1);
        resp_valid = 1'b1; resp_rd = 5'd9;
        chk_hz("sim.resp", !BYP);
        tick();
        resp_valid = 1'b0;
        chk_hz("sim.clr", 1'b0);
        check("sim.out0", {29'd0, outstanding}, 32'd0);
        rs1_d = '0;

        // Duplicate issue to a still-pending register
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        check("dup.err0", {31'd0, err}, 32'd0);
        tick();
        issue_valid = 1'b0;
        check("dup.err1", {31'd0, err}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rs1_d = 5'd12;
        chk_hz("dup.rst_pend", 1'b0);
        rs1_d = '0;

        // Underflow
        resp_valid = 1'b1; resp_rd = 5'd3;
        tick();
        resp_valid = 1'b0;
        check("und.err", {31'd0, err}, 32'd1);
        check("und.out", {29'd0, outstanding}, 32'd0);
        tick();
        check("und.sticky", {31'd0, err}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("und.rst", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
